// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the i2c transaction arbiter.
package i2c_arb_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  localparam int unsigned DEF_LAUNCH_TO  = 2047;
  localparam int unsigned DEF_RUN_TO     = 65535;
  localparam int unsigned DEF_RST_CYCLES = 1024;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARB     = 3'd1,
    LAUNCH  = 3'd2,
    RUN     = 3'd3,
    RECOVER = 3'd4,
    DONE    = 3'd5
  } arb_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  localparam int unsigned PW = $clog2(N);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = PW'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one i2c_master between NREQ requesters: round-robin grant, payload mux,
// busy tracking, result return and timeout recovery via a master reset pulse.
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned LAUNCH_TO  = DEF_LAUNCH_TO,
  parameter int unsigned RUN_TO     = DEF_RUN_TO,
  parameter int unsigned RST_CYCLES = DEF_RST_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            req_rw,
  input  logic [I2C_ADDR_W*NREQ-1:0] req_addr,
  input  logic [I2C_DATA_W*NREQ-1:0] req_blk,
  input  logic [I2C_DATA_W*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            done,
  output logic [I2C_DATA_W-1:0]      rdata,
  output logic                       nack,
  output logic                       timeout,
  output logic                       m_enable,
  output logic                       m_rw,
  output logic [I2C_ADDR_W-1:0]      m_addr,
  output logic [I2C_DATA_W-1:0]      m_blk,
  output logic [I2C_DATA_W-1:0]      m_wdata,
  output logic                       m_reset,
  input  logic                       m_busy,
  input  logic                       m_ack,
  input  logic [I2C_DATA_W-1:0]      m_rdata
);

  localparam int unsigned CNT_MAX = max3(LAUNCH_TO, RUN_TO, RST_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PW      = $clog2(NREQ);

  arb_state_e state_q, state_d;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]         ptr_q;
  logic [NREQ-1:0]       gnt_q, done_q;
  logic [I2C_DATA_W-1:0] rdata_q;
  logic                  nack_q, timeout_q;
  logic                  m_rw_q;
  logic [I2C_ADDR_W-1:0] m_addr_q;
  logic [I2C_DATA_W-1:0] m_blk_q, m_wdata_q;
  logic                  busy_m_q, busy_s_q;
  logic                  rst_hold_q;

  logic [NREQ-1:0]       grant;
  logic [PW-1:0]         own;
  logic                  sel_rw;
  logic [I2C_ADDR_W-1:0] sel_addr;
  logic [I2C_DATA_W-1:0] sel_blk, sel_wdata;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    own       = '0;
    sel_rw    = 1'b0;
    sel_addr  = '0;
    sel_blk   = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        own       = PW'(i);
        sel_rw    = req_rw[i];
        sel_addr  = req_addr[I2C_ADDR_W*i +: I2C_ADDR_W];
        sel_blk   = req_blk[I2C_DATA_W*i +: I2C_DATA_W];
        sel_wdata = req_wdata[I2C_DATA_W*i +: I2C_DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = ARB;
      ARB:     state_d = (|grant) ? LAUNCH : IDLE;
      LAUNCH: begin
        if (busy_s_q)                           state_d = RUN;
        else if (cnt_q == CNT_W'(LAUNCH_TO))    state_d = RECOVER;
      end
      RUN: begin
        if (!busy_s_q)                          state_d = DONE;
        else if (cnt_q == CNT_W'(RUN_TO))       state_d = RECOVER;
      end
      RECOVER: if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter restarts on every state change and saturates at its maximum.
  always_comb begin
    if (state_d != state_q)            cnt_d = '0;
    else if (cnt_q != CNT_W'(CNT_MAX)) cnt_d = cnt_q + 1'b1;
    else                               cnt_d = cnt_q;
  end

  always_comb begin
    m_enable = (state_q == LAUNCH);
    m_reset  = rst_hold_q || (state_q == RECOVER);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q      <= '0;
      ptr_q      <= PW'(NREQ - 1);
      gnt_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      nack_q     <= 1'b0;
      timeout_q  <= 1'b0;
      m_rw_q     <= 1'b0;
      m_addr_q   <= '0;
      m_blk_q    <= '0;
      m_wdata_q  <= '0;
      busy_m_q   <= 1'b0;
      busy_s_q   <= 1'b0;
      rst_hold_q <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      busy_m_q   <= m_busy;
      busy_s_q   <= busy_m_q;
      rst_hold_q <= 1'b0;
      done_q     <= '0;
      nack_q     <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        ARB: begin
          if (|grant) begin
            gnt_q     <= grant;
            ptr_q     <= own;
            m_rw_q    <= sel_rw;
            m_addr_q  <= sel_addr;
            m_blk_q   <= sel_blk;
            m_wdata_q <= sel_wdata;
          end
        end
        RUN: begin
          // m_ack/m_rdata are stable here: the master has been idle for two cycles.
          if (!busy_s_q) begin
            if (m_rw_q) rdata_q <= m_rdata;
            nack_q <= m_ack;
            done_q <= gnt_q;
            gnt_q  <= '0;
          end
        end
        RECOVER: begin
          if (state_d == DONE) begin
            nack_q    <= 1'b1;
            timeout_q <= 1'b1;
            done_q    <= gnt_q;
            gnt_q     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign nack    = nack_q;
  assign timeout = timeout_q;
  assign m_rw    = m_rw_q;
  assign m_addr  = m_addr_q;
  assign m_blk   = m_blk_q;
  assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter with a behavioural i2c master/slave and a completion scoreboard.
module tb_i2c_txn_arbiter;

  localparam int NREQ = 4;
  localparam int LTO  = 20;
  localparam int RTO  = 60;
  localparam int RSTC = 8;

  logic        clk;
  logic        reset;
  logic [3:0]  req, req_rw;
  logic [27:0] req_addr;
  logic [31:0] req_blk, req_wdata;
  logic [3:0]  gnt, done;
  logic [7:0]  rdata;
  logic        nack, timeout;
  logic        m_enable, m_rw, m_reset;
  logic [6:0]  m_addr;
  logic [7:0]  m_blk, m_wdata;
  logic        m_busy, m_ack;
  logic [7:0]  m_rdata;

  i2c_txn_arbiter #(
    .NREQ(NREQ), .LAUNCH_TO(LTO), .RUN_TO(RTO), .RST_CYCLES(RSTC)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_blk(req_blk), .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata),
    .nack(nack), .timeout(timeout), .m_enable(m_enable), .m_rw(m_rw), .m_addr(m_addr),
    .m_blk(m_blk), .m_wdata(m_wdata), .m_reset(m_reset), .m_busy(m_busy), .m_ack(m_ack),
    .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural master + slave: slave at 7'h50 ACKs; any other address hangs the master.
  logic [7:0] mem [256];
  int         ph, mc;
  logic [6:0] ma;
  logic       mrw;
  logic [7:0] mblk, mwd;

  always @(posedge clk) begin
    if (!reset || m_reset) begin
      ph      <= 0;
      mc      <= 0;
      m_busy  <= 1'b0;
      m_ack   <= 1'b0;
      if (!reset) begin
        m_rdata      <= 8'h00;
        mem[8'h20]   <= 8'h3C;
      end
    end else begin
      case (ph)
        0: if (m_enable) begin
          ph <= 1; mc <= 0; ma <= m_addr; mrw <= m_rw; mblk <= m_blk; mwd <= m_wdata;
        end
        1: if (mc == 2) begin m_busy <= 1'b1; ph <= 2; mc <= 0; end
           else mc <= mc + 1;
        2: if (mc == 11) begin
          if (ma == 7'h50) begin
            m_ack <= 1'b0;
            if (mrw) m_rdata <= mem[mblk];
            else     mem[mblk] <= mwd;
            m_busy <= 1'b0;
            ph     <= 0;
          end else begin
            m_ack <= 1'b1;
            ph    <= 3;
          end
        end else mc <= mc + 1;
        default: ;
      endcase
    end
  end

  typedef struct {
    int         idx;
    logic [7:0] rd;
    logic       nk;
    logic       to;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_last_rd = 8'h00;
  logic [3:0] grant_log[$];
  logic [3:0] gnt_prev = 4'h0;
  int         overlap_err = 0;

  always @(negedge clk) begin
    if (reset && (|done)) begin
      if (sb.size() == 0) chk("done_unexpected", 32'(done), 32'(0));
      else begin
        chk("done_owner", 32'(done), 32'(1) << sb[0].idx);
        chk("done_rdata", 32'(rdata), 32'(sb[0].rd));
        chk("done_nack", 32'(nack), 32'(sb[0].nk));
        chk("done_timeout", 32'(timeout), 32'(sb[0].to));
        void'(sb.pop_front());
      end
    end
    if (!$onehot0(gnt)) overlap_err <= overlap_err + 1;
    if (gnt != 4'h0 && gnt != gnt_prev) grant_log.push_back(gnt);
    gnt_prev <= gnt;
  end

  task automatic post(input int i, input logic rw, input logic [6:0] a,
                      input logic [7:0] b, input logic [7:0] w);
    req_rw[i]             = rw;
    req_addr[7*i +: 7]    = a;
    req_blk[8*i +: 8]     = b;
    req_wdata[8*i +: 8]   = w;
    req[i]                = 1'b1;
  endtask

  task automatic expect_done(input int i, input logic rd, input logic [7:0] rv,
                             input logic nk, input logic to);
    if (rd) exp_last_rd = rv;
    sb.push_back('{idx: i, rd: exp_last_rd, nk: nk, to: to});
  endtask

  task automatic wait_dones(input int n, input int budget, input string tag);
    int k = 0;
    int c = 0;
    while (k < n && c < budget) begin
      @(negedge clk);
      c++;
      if (|done) k++;
    end
    if (k < n) chk({tag, "_wait"}, 32'(k), 32'(n));
  endtask

  task automatic wait_run(input int budget, input string tag);
    logic seen = 1'b0;
    int   c    = 0;
    logic ok   = 1'b0;
    while (c < budget) begin
      @(negedge clk);
      c++;
      if (m_enable) seen = 1'b1;
      else if (seen) begin ok = 1'b1; break; end
    end
    if (!ok) chk({tag, "_run_wait"}, 32'(ok), 32'(1));
  endtask

  initial begin
    int rst_cnt;
    reset = 1'b0; req = '0; req_rw = '0; req_addr = '0; req_blk = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));
    chk("rst_status", 32'({nack, timeout}), 32'(0));
    chk("rst_m_payload", 32'({m_enable, m_rw, m_addr, m_blk, m_wdata}), 32'(0));
    chk("rst_m_reset", 32'(m_reset), 32'(1));
    reset = 1'b1;
    @(negedge clk);
    chk("rst_release_m_reset", 32'(m_reset), 32'(0));

    // 1: single write, latency check
    post(0, 1'b0, 7'h50, 8'h10, 8'hA5);
    expect_done(0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_enable_early", 32'(m_enable), 32'(0));
    @(negedge clk);
    chk("t1_enable_2clk", 32'(m_enable), 32'(1));
    chk("t1_gnt", 32'(gnt), 32'(4'b0001));
    chk("t1_payload", 32'({m_rw, m_addr, m_blk, m_wdata}), 32'({1'b0, 7'h50, 8'h10, 8'hA5}));
    wait_dones(1, 200, "t1");
    req[0] = 1'b0;

    // 2: single read
    @(negedge clk);
    post(2, 1'b1, 7'h50, 8'h20, 8'h00);
    expect_done(2, 1'b1, 8'h3C, 1'b0, 1'b0);
    wait_dones(1, 200, "t2");
    req[2] = 1'b0;

    // 3: all four held high after a fresh reset
    @(negedge clk);
    reset = 1'b0; exp_last_rd = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    grant_log.delete();
    post(0, 1'b0, 7'h50, 8'h30, 8'h11);
    post(1, 1'b1, 7'h50, 8'h10, 8'h00);
    post(2, 1'b1, 7'h50, 8'h20, 8'h00);
    post(3, 1'b0, 7'h50, 8'h31, 8'h22);
    expect_done(0, 1'b0, 8'h00, 1'b0, 1'b0);
    expect_done(1, 1'b1, 8'hA5, 1'b0, 1'b0);
    expect_done(2, 1'b1, 8'h3C, 1'b0, 1'b0);
    expect_done(3, 1'b0, 8'h00, 1'b0, 1'b0);
    expect_done(0, 1'b0, 8'h00, 1'b0, 1'b0);
    wait_dones(5, 600, "t3");
    req = '0;
    chk("t3_grant_count", 32'(grant_log.size()), 32'(5));
    for (int i = 0; i < 5; i++)
      if (i < grant_log.size()) chk($sformatf("t3_grant%0d", i), 32'(grant_log[i]),
                                    32'(1) << (i % 4));

    // 4: unacknowledged address hangs the master; run timeout and recovery
    @(negedge clk);
    post(1, 1'b0, 7'h22, 8'h00, 8'h00);
    expect_done(1, 1'b0, 8'h00, 1'b1, 1'b1);
    rst_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (m_reset) rst_cnt++;
      if (|done) break;
    end
    req[1] = 1'b0;
    chk("t4_m_reset_cycles", 32'(rst_cnt), 32'(RSTC));
    @(negedge clk);
    chk("t4_status_cleared", 32'({nack, timeout}), 32'(0));
    post(3, 1'b0, 7'h50, 8'h40, 8'h77);
    expect_done(3, 1'b0, 8'h00, 1'b0, 1'b0);
    wait_dones(1, 200, "t4_next");
    req[3] = 1'b0;

    // 5: reset during RUN
    @(negedge clk);
    post(1, 1'b0, 7'h50, 8'h41, 8'h55);
    wait_run(200, "t5");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_gnt", 32'(gnt), 32'(0));
    chk("t5_done", 32'(done), 32'(0));
    chk("t5_m_outputs", 32'({m_enable, m_rw, m_addr, m_blk, m_wdata}), 32'(0));
    chk("t5_m_reset", 32'(m_reset), 32'(1));
    req = '0; exp_last_rd = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_m_reset_release", 32'(m_reset), 32'(0));
    post(2, 1'b1, 7'h50, 8'h20, 8'h00);
    expect_done(2, 1'b1, 8'h3C, 1'b0, 1'b0);
    wait_dones(1, 200, "t5_restart");
    req[2] = 1'b0;

    // 6: request dropped while running still completes
    @(negedge clk);
    post(1, 1'b0, 7'h50, 8'h50, 8'h99);
    expect_done(1, 1'b0, 8'h00, 1'b0, 1'b0);
    wait_run(200, "t6");
    req[1] = 1'b0;
    wait_dones(1, 200, "t6");
    repeat (3) @(negedge clk);
    chk("t6_idle_gnt", 32'(gnt), 32'(0));
    chk("t6_idle_enable", 32'(m_enable), 32'(0));

    chk("sb_empty", 32'(sb.size()), 32'(0));
    chk("gnt_overlap", 32'(overlap_err), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
